skew_stream_feeder: RTL
=======================

// Module: skew_stream_feeder
// PURPOSE
//  Parametrised diagonal-skew feeder for the systolic array edge. Captures a LANES x DEPTH
//  operand matrix through a valid/ready load port, then streams it one beat at a time.
//  Each beat carries one element per lane, with lane i delayed by i beats and zero-filled
//  outside its window. Supports rectangular shapes, row/column-major source layout,
//  reversed skew direction, output backpressure, flush and back-to-back loads.
// PARAMETERS
//  WIDTH  4  element width in bits
//  LANES  3  output lanes (array edge length)
//  DEPTH  3  elements per lane (reduction length K)
// PORTS
//  clock          in   1                  single clock, rising edge
//  reset          in   1                  asynchronous, active-high
//  flush          in   1                  sync abort, return to IDLE
//  load_valid     in   1                  in_mat/cfg valid
//  load_ready     out  1                  load accepted when load_valid&&load_ready
//  in_mat         in   LANES*DEPTH*WIDTH  flat matrix, element n at [n*WIDTH +: WIDTH]
//  cfg_colmajor   in   1                  0: lane i elem k = n i*DEPTH+k; 1: n k*LANES+i
//  cfg_rev_skew   in   1                  0: lane i delay i; 1: lane i delay LANES-1-i
//  out_valid      out  1                  out_data valid
//  out_ready      in   1                  consumer accepts beat
//  out_data       out  LANES*WIDTH        lane i at [i*WIDTH +: WIDTH]
//  out_last       out  1                  final beat of matrix (qualified by out_valid)
//  busy           out  1                  state==STREAM
// BEHAVIOUR
//  - Reset: state IDLE, beat=0, out_valid=0, out_last=0, busy=0, load_ready=1, out_data=0.
//    Buffer contents are don't-care. Reset mid-stream discards the matrix immediately.
//  - NBEATS = DEPTH+LANES-1. beat counter is $clog2(NBEATS+1) bits, unsigned, no wrap past NBEATS-1.
//  - FSM IDLE: load_ready=1. On load handshake, capture in_mat, cfg_colmajor and cfg_rev_skew
//    into registers; beat<=0; go STREAM. out_valid rises the cycle after the handshake (latency 1).
//  - FSM STREAM: out_valid=1.
//    Lane i element at beat t: k = t - d_i, with d_i = i or LANES-1-i (per the captured cfg).
//    Lane output is elem(i,k) when 0<=k<DEPTH, else 0.
//  - Handshake out_valid&&out_ready advances beat. On stall, out_data/out_last are held
//    stable, and config changes on cfg_* inputs have no effect mid-stream.
//  - out_last = (beat==NBEATS-1). Handshake on the last beat -> IDLE, unless reloading.
//  - Back-to-back: load_ready is also 1 in STREAM when beat==NBEATS-1 && out_ready.
//    Simultaneous last-beat and load handshakes capture the new matrix, set beat<=0 and
//    stay in STREAM, giving a zero-bubble transition.
//  - flush: next state IDLE, out_valid=0, beat=0. load_ready=0 while flush=1, so flush
//    beats load. Flush in IDLE is a no-op.
//  - out_data is 0 whenever out_valid=0. It is derived from registered state only; there is
//    no combinational path from in_mat or cfg_* to out_data.
//  - Degenerate LANES=1: NBEATS=DEPTH, pass-through serialiser. DEPTH=1: pure diagonal.
// STRUCTURE
//  - skew_pkg: typedef enum logic {IDLE,STREAM} skew_state_t; function nbeats(LANES,DEPTH);
//    localparam-style helpers for counter width.
//  - Sub-module skew_lane_sel (one per lane, via generate).
//    Inputs: beat, lane index, captured cfg, flat buffer. Output: lane element or zero.
//  - Top holds the FSM, beat counter, matrix/cfg registers and handshake logic.
// TESTING  (WIDTH=4, LANES=3, DEPTH=3, in_mat n=0..8 -> values 1..9, lane0 listed first)
//  1 Row-major, no stall -> beats t0..t4: {1,0,0} {2,4,0} {3,5,7} {0,6,8} {0,0,9};
//    out_last at t4; out_valid 1 cycle after load.
//  2 Col-major -> {1,0,0} {4,2,0} {7,5,3} {0,8,6} {0,0,9}.
//  3 Rev-skew, row-major -> {0,0,7} {0,4,8} {1,5,9} {2,6,0} {3,0,0}.
//  4 out_ready low 3 cycles at t2 -> {3,5,7} held 4 cycles, then t3..t4 normal.
//    load_valid during the stall is not accepted.
//  5 Second load (values 10..18 mod 16) presented during t4 with out_ready=1 -> next cycle
//    gives new t0 {10,0,0}; out_valid never drops.
//  6 flush at t1 with load_valid=1 -> out_valid 0 next cycle, load_ready 0 during flush.
//    Reset pulse mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/skew_pkg.sv
// Shared types and sizing helpers for the diagonal-skew operand feeder.
package skew_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } skew_state_t;

    function automatic int nbeats(input int lanes, input int depth);
        return depth + lanes - 1;
    endfunction

    // Beat counter must hold 0..NBEATS.
    function automatic int beat_w(input int lanes, input int depth);
        return $clog2(nbeats(lanes, depth) + 1);
    endfunction

    function automatic int idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/skew_lane_sel.sv
// One lane of the feeder: picks elem(lane, beat - delay) from the captured matrix, or zero.
module skew_lane_sel
    import skew_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LANES = 3,
    parameter int DEPTH = 3,
    parameter int BW    = beat_w(LANES, DEPTH),
    parameter int IW    = idx_w(LANES)
) (
    input  logic [BW-1:0]                  beat,
    input  logic [IW-1:0]                  lane_idx,
    input  logic                           colmajor,
    input  logic                           rev_skew,
    input  logic [LANES*DEPTH*WIDTH-1:0]   mat,
    output logic [WIDTH-1:0]               elem
);

    logic [BW-1:0] delay;

    always_comb begin
        if (rev_skew) delay = BW'(LANES - 1) - BW'(lane_idx);
        else          delay = BW'(lane_idx);
    end

    // Match beat against every in-window (lane, k) pair; no hit means zero-fill.
    always_comb begin
        elem = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (lane_idx == IW'(l) && beat == BW'(k) + delay) begin
                    if (colmajor) elem = mat[(k*LANES + l)*WIDTH +: WIDTH];
                    else          elem = mat[(l*DEPTH + k)*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/skew_stream_feeder.sv
// Captures a LANES x DEPTH matrix and streams it as skewed diagonal beats with valid/ready.
module skew_stream_feeder
    import skew_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LANES = 3,
    parameter int DEPTH = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [LANES*DEPTH*WIDTH-1:0]  in_mat,
    input  logic                          cfg_colmajor,
    input  logic                          cfg_rev_skew,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*WIDTH-1:0]        out_data,
    output logic                          out_last,
    output logic                          busy
);

    localparam int NBEATS = nbeats(LANES, DEPTH);
    localparam int BW     = beat_w(LANES, DEPTH);
    localparam int IW     = idx_w(LANES);
    localparam int MW     = LANES * DEPTH * WIDTH;

    skew_state_t           state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [MW-1:0]         mat_q, mat_d;
    logic                  colmajor_q, colmajor_d;
    logic                  rev_q, rev_d;

    logic                  streaming;
    logic                  at_last;
    logic                  load_hs;
    logic                  out_hs;
    logic [LANES-1:0][WIDTH-1:0] lane_elem;

    assign streaming = (state_q == STREAM);
    assign at_last   = (beat_q == BW'(NBEATS - 1));

    // Reload is only offered when the final beat is being consumed this cycle.
    assign load_ready = !flush && (!streaming || (at_last && out_ready));
    assign load_hs    = load_valid && load_ready;
    assign out_hs     = streaming && out_ready;

    assign out_valid = streaming;
    assign busy      = streaming;
    assign out_last  = streaming && at_last;
    assign out_data  = streaming ? lane_elem : '0;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        mat_d      = mat_q;
        colmajor_d = colmajor_q;
        rev_d      = rev_q;
        if (flush) begin
            state_d = IDLE;
            beat_d  = '0;
        end else if (load_hs) begin
            state_d    = STREAM;
            beat_d     = '0;
            mat_d      = in_mat;
            colmajor_d = cfg_colmajor;
            rev_d      = cfg_rev_skew;
        end else if (out_hs) begin
            if (at_last) begin
                state_d = IDLE;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            mat_q      <= '0;
            colmajor_q <= 1'b0;
            rev_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            mat_q      <= mat_d;
            colmajor_q <= colmajor_d;
            rev_q      <= rev_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_lane_sel #(
            .WIDTH (WIDTH),
            .LANES (LANES),
            .DEPTH (DEPTH),
            .BW    (BW),
            .IW    (IW)
        ) u_sel (
            .beat     (beat_q),
            .lane_idx (IW'(i)),
            .colmajor (colmajor_q),
            .rev_skew (rev_q),
            .mat      (mat_q),
            .elem     (lane_elem[i])
        );
    end

endmodule
